apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Shares one APB master port, built from the team's `axi2apb` APB structs, between NumReq simple requesters using round-robin arbitration.
- Sequences the APB SETUP/ACCESS protocol, including `psel`, which the request struct does not carry.
- Returns read data and error status to the requester whose transfer completed.
- Bounds slave stalls with a timeout that terminates the transfer with an error response.

Parameters:
- NumReq, 2, number of requesters; legal values are 1 or more.
- TimeoutCycles, 256, number of ACCESS cycles without `pready` before forced error completion; 0 disables the timeout.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- req_valid_i  input  NumReq  requester i has a pending transfer; held stable until accepted
- req_ready_o  output  NumReq  one-hot accept; transfer accepted on valid&ready
- req_addr_i  input  NumReq*32  per-requester address
- req_write_i  input  NumReq  1=write, 0=read
- req_wdata_i  input  NumReq*32  write data
- req_strb_i  input  NumReq*4  write strobes
- req_prot_i  input  NumReq*3  protection (`axi_pkg::prot_t`)
- rsp_valid_o  output  NumReq  one-cycle completion pulse, one-hot
- rsp_rdata_o  output  32  read data, valid with any `rsp_valid_o` bit
- rsp_err_o  output  1  `pslverr` or timeout, valid with any `rsp_valid_o` bit
- apb_req_o  output  73  `axi2apb::apb_req_t` (paddr, pprot, penable, pwrite, pwdata, pstrb)
- apb_psel_o  output  1  APB select
- apb_resp_i  input  34  `axi2apb::apb_resp_t` (pready, prdata, pslverr)

Behaviour:
- Reset values:
  - `apb_req_o` = all zero; `apb_psel_o` = 0.
  - `req_ready_o` = 0; `rsp_valid_o` = 0; `rsp_rdata_o` = 0; `rsp_err_o` = 0.
  - FSM = IDLE; timeout counter = 0; RR pointer = NumReq-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any `req_valid_i` is set, the winner is the first set bit searching from pointer+1 modulo NumReq.
  - `req_ready_o[winner]` = 1 combinationally in that cycle.
  - addr/write/wdata/strb/prot and the winner index are latched; pointer is set to the winner; next state is SETUP.
  - With no valid, `req_ready_o` = 0 and the FSM stays in IDLE.
  - `req_ready_o` is 0 in every state other than IDLE.
- SETUP (exactly 1 cycle):
  - `psel` = 1, `penable` = 0; paddr/pwrite/pwdata/pprot come from the latched values.
  - pstrb = latched strb for writes, 4'b0 for reads.
  - Next state is ACCESS; the counter is cleared.
- ACCESS:
  - `psel` = 1, `penable` = 1, other fields unchanged.
  - On `pready` = 1: register `prdata` (writes return 0) and `pslverr`; `rsp_valid_o[winner]` = 1 in the next cycle; next state is IDLE.
  - On `pready` = 0: counter increments.
  - When TimeoutCycles ≠ 0 and counter == TimeoutCycles-1 with `pready` still 0: force completion next cycle with `rsp_err_o` = 1, `rsp_rdata_o` = 0; next state is IDLE. `psel` drops with no handshake.
  - `pready` in the final allowed cycle takes precedence over the timeout.
- After completion, IDLE:
  - `psel` = 0, `penable` = 0.
  - paddr/pwrite/pwdata/pstrb/pprot hold their last values.
- Latency, no wait states:
  - accept in cycle N, SETUP in N+1, ACCESS in N+2 with `pready`, `rsp_valid_o` in N+3.
  - A new accept may occur in the same cycle as `rsp_valid_o` (N+3), so back-to-back transfers have a 3-cycle period.
- Response outputs:
  - `rsp_valid_o` is a single-cycle pulse; there is no backpressure on responses.
  - `rsp_rdata_o` and `rsp_err_o` hold until the next completion.
- Fairness: a requester that has just been served has lowest priority at the next arbitration. A requester that deasserts valid before acceptance is simply not granted.
- Reset asserted mid-transfer: all state returns to reset values immediately. No response is produced for the aborted transfer; `psel` drops asynchronously.
- NumReq = 1: arbitration reduces to a pass-through; the pointer is constant.

Test Plan:
- Single write, req0: addr=0x1000_0040, wdata=0xDEAD_BEEF, strb=4'hF, `pready` in first ACCESS cycle -> ready@N, SETUP@N+1 (psel=1, penable=0, pwrite=1), ACCESS@N+2, `rsp_valid_o`=2'b01@N+3, err=0.
- Single read, req1: addr=0x20, slave holds `pready` low 3 cycles then returns 0x1234_5678 with pslverr=1 -> pstrb=0 throughout, ACCESS lasts 4 cycles, `rsp_valid_o`=2'b10, rdata=0x1234_5678, err=1.
- Contention: both requesters continuously valid from reset for 4 transfers -> grant order 0,1,0,1; each transfer has exactly one SETUP; `rsp_valid_o` is one-hot and matches the grant order.
- Timeout with TimeoutCycles=8: `pready` stuck 0 -> exactly 8 ACCESS cycles, then psel=0, err=1, rdata=0; the next request is accepted normally.
- Reset mid-ACCESS: assert rst_ni=0 in the 2nd ACCESS cycle -> psel/penable/`req_ready_o`/`rsp_valid_o` go 0 immediately; after release, req0 wins first.
- `pready` asserted in the same cycle the timeout would fire (TimeoutCycles=4, `pready` in 4th ACCESS cycle) -> normal completion, err = `pslverr` value, no timeout error.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NumReq requesters.
// It runs the SETUP/ACCESS sequence and ends stalled transfers with an error after a timeout.
module apb_master_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  logic [NumReq*32-1:0]  req_addr_i,
    input  logic [NumReq-1:0]     req_write_i,
    input  logic [NumReq*32-1:0]  req_wdata_i,
    input  logic [NumReq*4-1:0]   req_strb_i,
    input  logic [NumReq*3-1:0]   req_prot_i,
    output logic [NumReq-1:0]     rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [72:0]           apb_req_o,
    output logic                  apb_psel_o,
    input  logic [33:0]           apb_resp_i
);
    // state  | meaning
    // IDLE   | no transfer in flight; arbitrate among valid requesters
    // SETUP  | psel high, penable low, exactly one cycle
    // ACCESS | psel and penable high until pready or timeout
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [2:0]        prot_q, prot_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    apb_resp_t       resp;
    logic [IdxW-1:0] win;
    logic            win_found;
    logic [31:0]     sel_addr;
    logic            sel_write;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_strb;
    logic [2:0]      sel_prot;
    logic            timeout_hit;

    assign resp = apb_resp_i;
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

    // Two passes: requesters above the pointer first, then wrap around to the rest.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int j = 0; j < NumReq; j++) begin
            if (!win_found && req_valid_i[j] && (j > int'(ptr_q))) begin
                win       = IdxW'(j);
                win_found = 1'b1;
            end
        end
        for (int j = 0; j < NumReq; j++) begin
            if (!win_found && req_valid_i[j] && (j <= int'(ptr_q))) begin
                win       = IdxW'(j);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (win == IdxW'(j)) begin
                sel_addr  = req_addr_i[j*32 +: 32];
                sel_write = req_write_i[j];
                sel_wdata = req_wdata_i[j*32 +: 32];
                sel_strb  = req_strb_i[j*4 +: 4];
                sel_prot  = req_prot_i[j*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        prot_d      = prot_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                // Gating with rst_ni keeps ready low while reset is held.
                if (win_found && rst_ni) begin
                    req_ready_o[win] = 1'b1;
                    ptr_d   = win;
                    idx_d   = win;
                    addr_d  = sel_addr;
                    write_d = sel_write;
                    wdata_d = sel_wdata;
                    strb_d  = sel_write ? sel_strb : 4'b0;
                    prot_d  = sel_prot;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (resp.pready) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    rsp_rdata_d        = write_q ? 32'd0 : resp.prdata;
                    rsp_err_d          = resp.pslverr;
                    state_d            = IDLE;
                end else if (timeout_hit) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    rsp_rdata_d        = 32'd0;
                    rsp_err_d          = 1'b1;
                    state_d            = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= IdxW'(NumReq - 1);
            idx_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            prot_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            prot_q      <= prot_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Layout: paddr, pprot, penable, pwrite, pwdata, pstrb (MSB first).
    assign apb_req_o   = {addr_q, prot_q, (state_q == ACCESS), write_q, wdata_q, strb_q};
    assign apb_psel_o  = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
